// File: rtl/hicore_icb_arbt_if.sv
// rtl/hicore_icb_arbt_if.sv - ICB command/response bundle used on every arbiter port
interface hicore_icb_arbt_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic            icb_cmd_read;
    logic [AW-1:0]   icb_cmd_addr;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic            icb_rsp_err;
    logic [DW-1:0]   icb_rsp_rdata;

    // Side that issues commands and consumes responses
    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready,
        input  icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    // Side that accepts commands and produces responses
    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready,
        output icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/hicore_icb_arbt.sv
// rtl/hicore_icb_arbt.sv - 2:1 ICB arbiter (LSU=m0, IFU=m1); HICORE_ARBT_RR_EN selects round-robin
module hicore_icb_arbt #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    hicore_icb_arbt_if.slave  i_m0,
    hicore_icb_arbt_if.slave  i_m1,
    hicore_icb_arbt_if.master o_icb
);
    localparam int              PW       = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int              CW       = $clog2(OUTS_DEPTH + 1);
    localparam logic [PW-1:0]   PTR_LAST = PW'(OUTS_DEPTH - 1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(OUTS_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t     r_state;
    logic            r_lock_id;
    logic            r_fifo [OUTS_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_win;
    logic            w_gnt;
    logic            w_gnt_valid;
    logic            w_full;
    logic            w_empty;
    logic            w_cmd_valid;
    logic            w_cmd_rdy;
    logic            w_push;
    logic            w_pop;
    logic            w_head;
    logic            w_rsp_ready;

`ifdef HICORE_ARBT_RR_EN
    logic            r_rr;

    // Round-robin winner: the rr port breaks ties, otherwise whoever is valid
    always_comb begin
        if (i_m0.icb_cmd_valid && i_m1.icb_cmd_valid) begin
            w_win = r_rr;
        end else begin
            w_win = i_m1.icb_cmd_valid & ~i_m0.icb_cmd_valid;
        end
    end

    // Hand priority to the other port after every accepted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_push) begin
            r_rr <= ~w_gnt;
        end
    end
`else
    // Fixed priority: LSU wins whenever it asks
    assign w_win = i_m1.icb_cmd_valid & ~i_m0.icb_cmd_valid;
`endif

    // Grant is frozen while a command sits un-accepted downstream
    assign w_gnt       = (r_state == S_LOCKED) ? r_lock_id : w_win;
    assign w_gnt_valid = w_gnt ? i_m1.icb_cmd_valid : i_m0.icb_cmd_valid;

    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);

    assign w_cmd_valid = w_gnt_valid & ~w_full;
    assign w_cmd_rdy   = o_icb.icb_cmd_ready & ~w_full;
    assign w_push      = w_cmd_valid & o_icb.icb_cmd_ready;

    assign o_icb.icb_cmd_valid = w_cmd_valid;
    assign o_icb.icb_cmd_read  = w_gnt ? i_m1.icb_cmd_read  : i_m0.icb_cmd_read;
    assign o_icb.icb_cmd_addr  = w_gnt ? i_m1.icb_cmd_addr  : i_m0.icb_cmd_addr;
    assign o_icb.icb_cmd_wdata = w_gnt ? i_m1.icb_cmd_wdata : i_m0.icb_cmd_wdata;
    assign o_icb.icb_cmd_wmask = w_gnt ? i_m1.icb_cmd_wmask : i_m0.icb_cmd_wmask;

    assign i_m0.icb_cmd_ready  = w_cmd_rdy & ~w_gnt;
    assign i_m1.icb_cmd_ready  = w_cmd_rdy &  w_gnt;

    // Responses go to whoever issued the oldest outstanding command
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_rsp_ready = ~w_empty & (w_head ? i_m1.icb_rsp_ready : i_m0.icb_rsp_ready);
    assign w_pop       = o_icb.icb_rsp_valid & w_rsp_ready;

    assign o_icb.icb_rsp_ready = w_rsp_ready;
    assign i_m0.icb_rsp_valid  = o_icb.icb_rsp_valid & ~w_empty & ~w_head;
    assign i_m1.icb_rsp_valid  = o_icb.icb_rsp_valid & ~w_empty &  w_head;
    assign i_m0.icb_rsp_err    = o_icb.icb_rsp_err;
    assign i_m1.icb_rsp_err    = o_icb.icb_rsp_err;
    assign i_m0.icb_rsp_rdata  = o_icb.icb_rsp_rdata;
    assign i_m1.icb_rsp_rdata  = o_icb.icb_rsp_rdata;

    // Lock FSM: latch the grant when downstream stalls, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lock_id <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_valid && !o_icb.icb_cmd_ready) begin
                        r_state   <= S_LOCKED;
                        r_lock_id <= w_gnt;
                    end
                end
                S_LOCKED: begin
                    if (w_push) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ID storage: contents need no reset, only the pointers and count do
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_gnt;
        end
    end

    // ID FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_hicore_icb_arbt.sv
// tb/tb_hicore_icb_arbt.sv - self-checking bench for hicore_icb_arbt against a queue-based model
module tb_hicore_icb_arbt;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef HICORE_ARBT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: issue-ordered outstanding ids, sticky grant, rr priority
    int q[$];
    int pend = -1;
    int rr   = 0;
    bit hs0, hs1;
    bit act0, act1;

    always #5 clk = ~clk;

    hicore_icb_arbt_if #(.AW(AW), .DW(DW)) m0_if ();
    hicore_icb_arbt_if #(.AW(AW), .DW(DW)) m1_if ();
    hicore_icb_arbt_if #(.AW(AW), .DW(DW)) o_if ();

    hicore_icb_arbt #(.AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .i_m0  (m0_if),
        .i_m1  (m1_if),
        .o_icb (o_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        m0_if.icb_cmd_valid = 1'b0; m0_if.icb_cmd_read = 1'b0; m0_if.icb_cmd_addr = '0;
        m0_if.icb_cmd_wdata = '0;   m0_if.icb_cmd_wmask = '0;  m0_if.icb_rsp_ready = 1'b0;
        m1_if.icb_cmd_valid = 1'b0; m1_if.icb_cmd_read = 1'b0; m1_if.icb_cmd_addr = '0;
        m1_if.icb_cmd_wdata = '0;   m1_if.icb_cmd_wmask = '0;  m1_if.icb_rsp_ready = 1'b0;
        o_if.icb_cmd_ready  = 1'b0; o_if.icb_rsp_valid = 1'b0; o_if.icb_rsp_err = 1'b0;
        o_if.icb_rsp_rdata  = '0;
    endtask

    // Compare every DUT output against the model, then advance the model by one cycle
    task automatic sample();
        int gnt;
        int head;
        bit full, empty, gv, exp_ov, exp_rr, push, pop;
        #4;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (pend >= 0)                                      gnt = pend;
        else if (m0_if.icb_cmd_valid && m1_if.icb_cmd_valid) gnt = RR ? rr : 0;
        else if (m1_if.icb_cmd_valid)                        gnt = 1;
        else                                                 gnt = 0;
        gv     = gnt ? m1_if.icb_cmd_valid : m0_if.icb_cmd_valid;
        exp_ov = gv && !full;
        chk("o_cmd_valid",  o_if.icb_cmd_valid,  exp_ov);
        chk("m0_cmd_ready", m0_if.icb_cmd_ready, (gnt == 0) && o_if.icb_cmd_ready && !full);
        chk("m1_cmd_ready", m1_if.icb_cmd_ready, (gnt == 1) && o_if.icb_cmd_ready && !full);
        if (exp_ov) begin
            chk("o_cmd_addr",  o_if.icb_cmd_addr,  gnt ? m1_if.icb_cmd_addr  : m0_if.icb_cmd_addr);
            chk("o_cmd_read",  o_if.icb_cmd_read,  gnt ? m1_if.icb_cmd_read  : m0_if.icb_cmd_read);
            chk("o_cmd_wdata", o_if.icb_cmd_wdata, gnt ? m1_if.icb_cmd_wdata : m0_if.icb_cmd_wdata);
            chk("o_cmd_wmask", o_if.icb_cmd_wmask, gnt ? m1_if.icb_cmd_wmask : m0_if.icb_cmd_wmask);
        end
        head   = empty ? 0 : q[0];
        exp_rr = !empty && (head ? m1_if.icb_rsp_ready : m0_if.icb_rsp_ready);
        chk("o_rsp_ready",  o_if.icb_rsp_ready,  exp_rr);
        chk("m0_rsp_valid", m0_if.icb_rsp_valid, o_if.icb_rsp_valid && !empty && head == 0);
        chk("m1_rsp_valid", m1_if.icb_rsp_valid, o_if.icb_rsp_valid && !empty && head == 1);
        if (!empty && o_if.icb_rsp_valid) begin
            chk("rsp_rdata", head ? m1_if.icb_rsp_rdata : m0_if.icb_rsp_rdata, o_if.icb_rsp_rdata);
            chk("rsp_err",   head ? m1_if.icb_rsp_err   : m0_if.icb_rsp_err,   o_if.icb_rsp_err);
        end
        push = exp_ov && o_if.icb_cmd_ready;
        pop  = o_if.icb_rsp_valid && exp_rr;
        hs0  = push && gnt == 0;
        hs1  = push && gnt == 1;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(gnt);
            pend = -1;
            rr   = 1 - gnt;
        end else if (exp_ov) begin
            pend = gnt;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        m0_if.icb_cmd_valid = 1'b0;
        m1_if.icb_cmd_valid = 1'b0;
        o_if.icb_rsp_valid  = 1'b1;
        m0_if.icb_rsp_ready = 1'b1;
        m1_if.icb_rsp_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            sample();
            advance();
        end
        o_if.icb_rsp_valid = 1'b0;
    endtask

    initial begin
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        sample();
        chk("rst_o_cmd_valid",  o_if.icb_cmd_valid,  1'b0);
        chk("rst_m0_cmd_ready", m0_if.icb_cmd_ready, 1'b0);
        chk("rst_m1_cmd_ready", m1_if.icb_cmd_ready, 1'b0);
        chk("rst_o_rsp_ready",  o_if.icb_rsp_ready,  1'b0);
        advance();

        // Both requesters valid for 4 cycles with downstream always ready
        m0_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_valid = 1'b1;
        o_if.icb_cmd_ready  = 1'b1; o_if.icb_rsp_valid = 1'b1;
        m0_if.icb_rsp_ready = 1'b1; m1_if.icb_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m0_if.icb_cmd_addr = 32'h100 + k;
            m1_if.icb_cmd_addr = 32'h200 + k;
            sample();
            chk("alt_gnt_m0", m0_if.icb_cmd_ready, RR ? 1 - (k % 2) : 1);
            chk("alt_gnt_m1", m1_if.icb_cmd_ready, RR ? (k % 2) : 0);
            advance();
        end
        drain();
        drive_idle();

        // Same-cycle pass-through and response routed to m0 only
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_read = 1'b1;
        m0_if.icb_cmd_addr  = 32'h8000_0000; o_if.icb_cmd_ready = 1'b1;
        sample();
        chk("pt_valid", o_if.icb_cmd_valid, 1'b1);
        chk("pt_addr",  o_if.icb_cmd_addr,  32'h8000_0000);
        chk("pt_read",  o_if.icb_cmd_read,  1'b1);
        advance();
        m0_if.icb_cmd_valid = 1'b0; o_if.icb_rsp_valid = 1'b1;
        o_if.icb_rsp_rdata  = 32'h1234_5678; m0_if.icb_rsp_ready = 1'b1;
        sample();
        chk("pt_rsp_m0",   m0_if.icb_rsp_valid, 1'b1);
        chk("pt_rdata_m0", m0_if.icb_rsp_rdata, 32'h1234_5678);
        chk("pt_rsp_m1",   m1_if.icb_rsp_valid, 1'b0);
        advance();
        drive_idle();

        // Grant lock: m1 stalled downstream, m0 arrives late
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_addr = 32'h1111_0000;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                m0_if.icb_cmd_valid = 1'b1;
                m0_if.icb_cmd_addr  = 32'h2222_0000;
            end
            sample();
            chk("lock_addr", o_if.icb_cmd_addr, 32'h1111_0000);
            advance();
        end
        o_if.icb_cmd_ready = 1'b1;
        sample();
        chk("lock_hs_m1", m1_if.icb_cmd_ready, 1'b1);
        chk("lock_hs_m0", m0_if.icb_cmd_ready, 1'b0);
        advance();
        m1_if.icb_cmd_valid = 1'b0;
        sample();
        chk("lock_next_m0", m0_if.icb_cmd_ready, 1'b1);
        advance();
        drain();
        drive_idle();

        // Outstanding limit with no push bypass
        m0_if.icb_cmd_valid = 1'b1; o_if.icb_cmd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m0_if.icb_cmd_addr = 32'h300 + k;
            sample();
            advance();
        end
        m0_if.icb_cmd_addr = 32'h302;
        sample();
        chk("full_blk_valid", o_if.icb_cmd_valid,  1'b0);
        chk("full_blk_rdy",   m0_if.icb_cmd_ready, 1'b0);
        advance();
        o_if.icb_rsp_valid = 1'b1; m0_if.icb_rsp_ready = 1'b1;
        sample();
        chk("full_nobypass", o_if.icb_cmd_valid, 1'b0);
        chk("full_pop_rdy",  o_if.icb_rsp_ready, 1'b1);
        advance();
        o_if.icb_rsp_valid = 1'b0;
        sample();
        chk("full_unblk", o_if.icb_cmd_valid, 1'b1);
        advance();
        drain();
        drive_idle();

        // In-order routing with error flag, then a spurious response
        o_if.icb_cmd_ready = 1'b1;
        m0_if.icb_cmd_valid = 1'b1; m0_if.icb_cmd_addr = 32'h400;
        sample(); advance();
        m0_if.icb_cmd_valid = 1'b0;
        m1_if.icb_cmd_valid = 1'b1; m1_if.icb_cmd_addr = 32'h500;
        sample(); advance();
        m1_if.icb_cmd_valid = 1'b0;
        o_if.icb_rsp_valid  = 1'b1; o_if.icb_rsp_err = 1'b0; o_if.icb_rsp_rdata = 32'hAAAA_0001;
        m0_if.icb_rsp_ready = 1'b1; m1_if.icb_rsp_ready = 1'b1;
        sample();
        chk("ord_m0_valid", m0_if.icb_rsp_valid, 1'b1);
        chk("ord_m0_err",   m0_if.icb_rsp_err,   1'b0);
        chk("ord_m1_idle",  m1_if.icb_rsp_valid, 1'b0);
        advance();
        o_if.icb_rsp_err = 1'b1; o_if.icb_rsp_rdata = 32'hBBBB_0002;
        sample();
        chk("ord_m1_valid", m1_if.icb_rsp_valid, 1'b1);
        chk("ord_m1_err",   m1_if.icb_rsp_err,   1'b1);
        chk("ord_m0_idle",  m0_if.icb_rsp_valid, 1'b0);
        advance();
        sample();
        chk("spur_ready", o_if.icb_rsp_ready,  1'b0);
        chk("spur_m0",    m0_if.icb_rsp_valid, 1'b0);
        chk("spur_m1",    m1_if.icb_rsp_valid, 1'b0);
        advance();
        drive_idle();

        // Random traffic: requesters hold a command until it is accepted
        act0 = 1'b0;
        act1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!act0 && $urandom_range(1, 0) == 1) begin
                act0 = 1'b1;
                m0_if.icb_cmd_read  = 1'($urandom_range(1, 0));
                m0_if.icb_cmd_addr  = $urandom;
                m0_if.icb_cmd_wdata = $urandom;
                m0_if.icb_cmd_wmask = 4'($urandom_range(15, 0));
            end
            if (!act1 && $urandom_range(1, 0) == 1) begin
                act1 = 1'b1;
                m1_if.icb_cmd_read  = 1'($urandom_range(1, 0));
                m1_if.icb_cmd_addr  = $urandom;
                m1_if.icb_cmd_wdata = $urandom;
                m1_if.icb_cmd_wmask = 4'($urandom_range(15, 0));
            end
            m0_if.icb_cmd_valid = act0;
            m1_if.icb_cmd_valid = act1;
            o_if.icb_cmd_ready  = ($urandom_range(2, 0) != 0);
            o_if.icb_rsp_valid  = (q.size() > 0) && ($urandom_range(1, 0) == 1);
            o_if.icb_rsp_err    = 1'($urandom_range(1, 0));
            o_if.icb_rsp_rdata  = $urandom;
            m0_if.icb_rsp_ready = 1'($urandom_range(1, 0));
            m1_if.icb_rsp_ready = 1'($urandom_range(1, 0));
            sample();
            if (hs0) act0 = 1'b0;
            if (hs1) act1 = 1'b0;
            advance();
        end
        drain();
        drive_idle();

        // Reset with commands outstanding drops all ids
        m0_if.icb_cmd_valid = 1'b1; o_if.icb_cmd_ready = 1'b1;
        sample(); advance();
        sample(); advance();
        drive_idle();
        rst = 1'b1;
        q.delete();
        pend = -1;
        rr   = 0;
        o_if.icb_rsp_valid = 1'b1; m0_if.icb_rsp_ready = 1'b1; m1_if.icb_rsp_ready = 1'b1;
        sample();
        chk("rst_mid_rsp_ready", o_if.icb_rsp_ready,  1'b0);
        chk("rst_mid_m0_rsp",    m0_if.icb_rsp_valid, 1'b0);
        advance();
        rst = 1'b0;
        sample();
        chk("post_rst_rsp_ready", o_if.icb_rsp_ready, 1'b0);
        advance();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
